// File: rtl/mandelbrot_pixel_gen.sv
// Raster-order pixel coordinate generator feeding the Mandelbrot iterator.
// Coordinates are accumulated from a latched origin/step; one pixel per accepted handshake.
module mandelbrot_pixel_gen #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int DATA_W = 27,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] cr_start,
  input  logic [DATA_W-1:0] ci_start,
  input  logic [DATA_W-1:0] dx,
  input  logic [DATA_W-1:0] dy,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] cr,
  output logic [DATA_W-1:0] ci,
  output logic [9:0]        x,
  output logic [8:0]        y,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  cr_start_l_q, cr_start_l_d;
  logic signed [DATA_W-1:0]  dx_l_q, dx_l_d;
  logic signed [DATA_W-1:0]  dy_l_q, dy_l_d;
  logic signed [DATA_W-1:0]  cr_q, cr_d;
  logic signed [DATA_W-1:0]  ci_q, ci_d;
  logic [9:0]                x_q, x_d;
  logic [8:0]                y_q, y_d;
  logic [ADDR_W-1:0]         pixel_addr_q, pixel_addr_d;
  logic                      out_valid_q, out_valid_d;
  logic                      busy_q, busy_d;
  logic                      frame_done_q, frame_done_d;

  always_comb begin
    state_d      = state_q;
    cr_start_l_d = cr_start_l_q;
    dx_l_d       = dx_l_q;
    dy_l_d       = dy_l_q;
    cr_d         = cr_q;
    ci_d         = ci_q;
    x_d          = x_q;
    y_d          = y_q;
    pixel_addr_d = pixel_addr_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cr_start_l_d = $signed(cr_start);
          dx_l_d       = $signed(dx);
          dy_l_d       = $signed(dy);
          cr_d         = $signed(cr_start);
          ci_d         = $signed(ci_start);
          x_d          = '0;
          y_d          = '0;
          pixel_addr_d = '0;
          out_valid_d  = 1'b1;
          busy_d       = 1'b1;
          state_d      = RUN;
        end
      end
      RUN: begin
        // Without a transfer every output holds, so valid is never withdrawn.
        if (out_valid_q && out_ready) begin
          if (x_q != X_LAST) begin
            x_d          = x_q + 10'd1;
            cr_d         = cr_q + dx_l_q;
            pixel_addr_d = pixel_addr_q + ADDR_W'(1);
          end else if (y_q != Y_LAST) begin
            x_d          = '0;
            y_d          = y_q + 9'd1;
            cr_d         = cr_start_l_q;
            ci_d         = ci_q - dy_l_q;
            pixel_addr_d = pixel_addr_q + ADDR_W'(1);
          end else begin
            out_valid_d  = 1'b0;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
            state_d      = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cr_start_l_q <= '0;
      dx_l_q       <= '0;
      dy_l_q       <= '0;
      cr_q         <= '0;
      ci_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      pixel_addr_q <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cr_start_l_q <= cr_start_l_d;
      dx_l_q       <= dx_l_d;
      dy_l_q       <= dy_l_d;
      cr_q         <= cr_d;
      ci_q         <= ci_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pixel_addr_q <= pixel_addr_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign cr         = cr_q;
  assign ci         = ci_q;
  assign x          = x_q;
  assign y          = y_q;
  assign pixel_addr = pixel_addr_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
